// File: rtl/core_types_pkg.sv
// Shared core types: physical-register/bank widths, issue-queue entry and
// issued-op records, and the writeback tag-match helper.
package core_types_pkg;

  localparam int LOG_PR_COUNT       = 6;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int PRF_BANK_COUNT     = 1 << LOG_PRF_BANK_COUNT;
  localparam int UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] bank_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] imm;
    pr_t         A_PR;
    logic        A_unneeded;
    logic        A_ready;
    pr_t         B_PR;
    logic        is_imm;
    logic        B_ready;
    pr_t         dest_PR;
  } alu_iq_entry_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic        is_imm;
    logic [31:0] imm;
    logic        A_unneeded;
    logic        A_forward;
    bank_t       A_bank;
    logic        B_forward;
    bank_t       B_bank;
    pr_t         dest_PR;
    logic        req_A_valid;
    pr_t         req_A_PR;
    logic        req_B_valid;
    pr_t         req_B_PR;
  } alu_issue_t;

  // A tag can only be produced by the bank its low bits name.
  function automatic logic wb_hit(
    input pr_t                                        pr,
    input logic [PRF_BANK_COUNT-1:0]                  wb_valid,
    input logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]  wb_upper
  );
    bank_t b;
    b = pr[LOG_PRF_BANK_COUNT-1:0];
    return wb_valid[b] & (wb_upper[b] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
  endfunction

endpackage

// File: rtl/pe_lsb.sv
// Lowest-index-first priority encoder: one-hot grant, binary index, any-set flag.
module pe_lsb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [WIDTH-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  assign o_onehot = i_req & (~i_req + WIDTH'(1));
  assign o_valid  = |i_req;

  // NOTE: the default assignment ahead of the loop keeps this block free of inferred latches.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_iq_param.sv
// Oldest-first compacting ALU issue queue: multi-way dispatch, banked writeback
// wakeup (including on the dispatch cycle) and a registered single-issue stage.
module alu_iq_param
  import core_types_pkg::*;
#(
  parameter int IQ_ENTRIES    = 8,
  parameter int DISPATCH_WAYS = 4
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic                                        flush_valid,
  input  logic [DISPATCH_WAYS-1:0]                    dispatch_valid_by_way,
  input  logic [DISPATCH_WAYS-1:0][3:0]               dispatch_op_by_way,
  input  logic [DISPATCH_WAYS-1:0][31:0]              dispatch_imm_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]  dispatch_A_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0]                    dispatch_A_unneeded_by_way,
  input  logic [DISPATCH_WAYS-1:0]                    dispatch_A_ready_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]  dispatch_B_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0]                    dispatch_is_imm_by_way,
  input  logic [DISPATCH_WAYS-1:0]                    dispatch_B_ready_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]  dispatch_dest_PR_by_way,
  output logic [DISPATCH_WAYS-1:0]                    dispatch_ready_by_way,
  input  logic [PRF_BANK_COUNT-1:0]                   WB_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]   WB_upper_PR_by_bank,
  input  logic                                        issue_ready,
  output logic                                        issue_valid,
  output logic [3:0]                                  issue_op,
  output logic                                        issue_is_imm,
  output logic [31:0]                                 issue_imm,
  output logic                                        issue_A_unneeded,
  output logic                                        issue_A_forward,
  output logic [LOG_PRF_BANK_COUNT-1:0]               issue_A_bank,
  output logic                                        issue_B_forward,
  output logic [LOG_PRF_BANK_COUNT-1:0]               issue_B_bank,
  output logic [LOG_PR_COUNT-1:0]                     issue_dest_PR,
  output logic                                        PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]                     PRF_req_A_PR,
  output logic                                        PRF_req_B_valid,
  output logic [LOG_PR_COUNT-1:0]                     PRF_req_B_PR
);

  localparam int IDX_W = $clog2(IQ_ENTRIES);
  localparam int CNT_W = $clog2(IQ_ENTRIES + 1);

  alu_iq_entry_t         r_q     [IQ_ENTRIES];
  alu_iq_entry_t         w_woken [IQ_ENTRIES];
  alu_iq_entry_t         w_next  [IQ_ENTRIES];
  alu_issue_t            r_issue, w_issue;
  logic [CNT_W-1:0]      w_count;
  logic [IQ_ENTRIES-1:0] w_a_match, w_b_match, w_a_fwd, w_b_fwd, w_ready, w_sel_onehot;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_valid;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      w_a_match[i] = r_q[i].valid & wb_hit(r_q[i].A_PR, WB_valid_by_bank, WB_upper_PR_by_bank);
      w_b_match[i] = r_q[i].valid & wb_hit(r_q[i].B_PR, WB_valid_by_bank, WB_upper_PR_by_bank);
      // Forwarding only applies to an operand that is actually read and not yet captured.
      w_a_fwd[i]   = w_a_match[i] & ~r_q[i].A_ready & ~r_q[i].A_unneeded;
      w_b_fwd[i]   = w_b_match[i] & ~r_q[i].B_ready & ~r_q[i].is_imm;
      w_ready[i]   = r_q[i].valid
                   & (r_q[i].A_ready | r_q[i].A_unneeded | w_a_match[i])
                   & (r_q[i].B_ready | r_q[i].is_imm     | w_b_match[i]);
      w_woken[i]         = r_q[i];
      w_woken[i].A_ready = r_q[i].A_ready | w_a_match[i];
      w_woken[i].B_ready = r_q[i].B_ready | w_b_match[i];
      w_count = w_count + CNT_W'(r_q[i].valid);
    end
  end

  // Credit comes from registered occupancy only; a same-cycle issue does not free a slot.
  always_comb begin
    dispatch_ready_by_way = '0;
    for (int w = 0; w < DISPATCH_WAYS; w++) begin
      dispatch_ready_by_way[w] = (IQ_ENTRIES - int'(w_count)) > w;
    end
  end

  pe_lsb #(.WIDTH(IQ_ENTRIES), .IDX_W(IDX_W)) u_select (
    .i_req    (w_ready & {IQ_ENTRIES{issue_ready & ~flush_valid}}),
    .o_onehot (w_sel_onehot),
    .o_idx    (w_sel_idx),
    .o_valid  (w_sel_valid)
  );

  always_comb begin
    w_issue = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      if (w_sel_onehot[i]) begin
        w_issue.valid       = 1'b1;
        w_issue.op          = r_q[i].op;
        w_issue.is_imm      = r_q[i].is_imm;
        w_issue.imm         = r_q[i].imm;
        w_issue.A_unneeded  = r_q[i].A_unneeded;
        w_issue.A_forward   = w_a_fwd[i];
        w_issue.A_bank      = w_a_fwd[i] ? r_q[i].A_PR[LOG_PRF_BANK_COUNT-1:0] : '0;
        w_issue.B_forward   = w_b_fwd[i];
        w_issue.B_bank      = w_b_fwd[i] ? r_q[i].B_PR[LOG_PRF_BANK_COUNT-1:0] : '0;
        w_issue.dest_PR     = r_q[i].dest_PR;
        w_issue.req_A_valid = ~r_q[i].A_unneeded & ~w_a_fwd[i];
        w_issue.req_A_PR    = w_issue.req_A_valid ? r_q[i].A_PR : '0;
        w_issue.req_B_valid = ~r_q[i].is_imm & ~w_b_fwd[i];
        w_issue.req_B_PR    = w_issue.req_B_valid ? r_q[i].B_PR : '0;
      end
    end
  end

  // Remove the selected entry, close the gap, then append accepted ways in way order.
  always_comb begin
    int            slot;
    alu_iq_entry_t ent;
    for (int i = 0; i < IQ_ENTRIES; i++) w_next[i] = w_woken[i];
    if (w_sel_valid) begin
      for (int i = 0; i < IQ_ENTRIES - 1; i++) begin
        if (i >= int'(w_sel_idx)) w_next[i] = w_woken[i + 1];
      end
      w_next[IQ_ENTRIES-1] = '0;
    end
    slot = int'(w_count) - int'(w_sel_valid);
    ent  = '0;
    for (int w = 0; w < DISPATCH_WAYS; w++) begin
      if (dispatch_valid_by_way[w] & dispatch_ready_by_way[w]) begin
        ent.valid      = 1'b1;
        ent.op         = dispatch_op_by_way[w];
        ent.imm        = dispatch_imm_by_way[w];
        ent.A_PR       = dispatch_A_PR_by_way[w];
        ent.A_unneeded = dispatch_A_unneeded_by_way[w];
        ent.A_ready    = dispatch_A_ready_by_way[w]
                       | wb_hit(dispatch_A_PR_by_way[w], WB_valid_by_bank, WB_upper_PR_by_bank);
        ent.B_PR       = dispatch_B_PR_by_way[w];
        ent.is_imm     = dispatch_is_imm_by_way[w];
        ent.B_ready    = dispatch_B_ready_by_way[w]
                       | wb_hit(dispatch_B_PR_by_way[w], WB_valid_by_bank, WB_upper_PR_by_bank);
        ent.dest_PR    = dispatch_dest_PR_by_way[w];
        w_next[IDX_W'(slot)] = ent;
        slot = slot + 1;
      end
    end
    if (flush_valid) begin
      for (int i = 0; i < IQ_ENTRIES; i++) w_next[i] = '0;
    end
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values regardless of block order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: entries are cleared whole, not just their valid bits, so no stored field leaves reset as X.
      for (int i = 0; i < IQ_ENTRIES; i++) r_q[i] <= '0;
      r_issue <= '0;
    end else begin
      r_q     <= w_next;
      r_issue <= w_issue;
    end
  end

  assign issue_valid      = r_issue.valid;
  assign issue_op         = r_issue.op;
  assign issue_is_imm     = r_issue.is_imm;
  assign issue_imm        = r_issue.imm;
  assign issue_A_unneeded = r_issue.A_unneeded;
  assign issue_A_forward  = r_issue.A_forward;
  assign issue_A_bank     = r_issue.A_bank;
  assign issue_B_forward  = r_issue.B_forward;
  assign issue_B_bank     = r_issue.B_bank;
  assign issue_dest_PR    = r_issue.dest_PR;
  assign PRF_req_A_valid  = r_issue.req_A_valid;
  assign PRF_req_A_PR     = r_issue.req_A_PR;
  assign PRF_req_B_valid  = r_issue.req_B_valid;
  assign PRF_req_B_PR     = r_issue.req_B_PR;

endmodule

// File: tb/tb_alu_iq_param.sv
// Bench for alu_iq_param: directed scenarios plus randomized traffic, all
// checked against a queue-based behavioural model of the issue queue.
module tb_alu_iq_param;

  localparam int N  = 8;
  localparam int DW = 4;
  localparam int NB = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               flush_valid;
  logic [DW-1:0]      dispatch_valid_by_way;
  logic [DW-1:0][3:0] dispatch_op_by_way;
  logic [DW-1:0][31:0] dispatch_imm_by_way;
  logic [DW-1:0][5:0] dispatch_A_PR_by_way;
  logic [DW-1:0]      dispatch_A_unneeded_by_way;
  logic [DW-1:0]      dispatch_A_ready_by_way;
  logic [DW-1:0][5:0] dispatch_B_PR_by_way;
  logic [DW-1:0]      dispatch_is_imm_by_way;
  logic [DW-1:0]      dispatch_B_ready_by_way;
  logic [DW-1:0][5:0] dispatch_dest_PR_by_way;
  logic [DW-1:0]      dispatch_ready_by_way;
  logic [NB-1:0]      WB_valid_by_bank;
  logic [NB-1:0][3:0] WB_upper_PR_by_bank;
  logic               issue_ready;
  logic               issue_valid;
  logic [3:0]         issue_op;
  logic               issue_is_imm;
  logic [31:0]        issue_imm;
  logic               issue_A_unneeded;
  logic               issue_A_forward;
  logic [1:0]         issue_A_bank;
  logic               issue_B_forward;
  logic [1:0]         issue_B_bank;
  logic [5:0]         issue_dest_PR;
  logic               PRF_req_A_valid;
  logic [5:0]         PRF_req_A_PR;
  logic               PRF_req_B_valid;
  logic [5:0]         PRF_req_B_PR;

  always #5 CLK = ~CLK;

  alu_iq_param #(.IQ_ENTRIES(N), .DISPATCH_WAYS(DW)) dut (
    .CLK(CLK), .RST(RST), .flush_valid(flush_valid),
    .dispatch_valid_by_way(dispatch_valid_by_way),
    .dispatch_op_by_way(dispatch_op_by_way),
    .dispatch_imm_by_way(dispatch_imm_by_way),
    .dispatch_A_PR_by_way(dispatch_A_PR_by_way),
    .dispatch_A_unneeded_by_way(dispatch_A_unneeded_by_way),
    .dispatch_A_ready_by_way(dispatch_A_ready_by_way),
    .dispatch_B_PR_by_way(dispatch_B_PR_by_way),
    .dispatch_is_imm_by_way(dispatch_is_imm_by_way),
    .dispatch_B_ready_by_way(dispatch_B_ready_by_way),
    .dispatch_dest_PR_by_way(dispatch_dest_PR_by_way),
    .dispatch_ready_by_way(dispatch_ready_by_way),
    .WB_valid_by_bank(WB_valid_by_bank),
    .WB_upper_PR_by_bank(WB_upper_PR_by_bank),
    .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_is_imm(issue_is_imm),
    .issue_imm(issue_imm), .issue_A_unneeded(issue_A_unneeded),
    .issue_A_forward(issue_A_forward), .issue_A_bank(issue_A_bank),
    .issue_B_forward(issue_B_forward), .issue_B_bank(issue_B_bank),
    .issue_dest_PR(issue_dest_PR),
    .PRF_req_A_valid(PRF_req_A_valid), .PRF_req_A_PR(PRF_req_A_PR),
    .PRF_req_B_valid(PRF_req_B_valid), .PRF_req_B_PR(PRF_req_B_PR)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] imm;
    logic [5:0]  a_pr;
    bit          a_un;
    bit          a_rdy;
    logic [5:0]  b_pr;
    bit          is_imm;
    bit          b_rdy;
    logic [5:0]  dest;
  } op_t;

  op_t         q[$];
  logic [50:0] exp_issue;
  logic [13:0] exp_prf;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // PR p lives in bank p mod 4 with upper part p div 4.
  function automatic bit hit(input logic [5:0] pr);
    int bank, upper;
    bank  = int'(pr) % NB;
    upper = int'(pr) / NB;
    return WB_valid_by_bank[2'(bank)] && (int'(WB_upper_PR_by_bank[2'(bank)]) == upper);
  endfunction

  task automatic model_update();
    int  sel;
    int  free;
    op_t o;
    bit  af, bf, ra, rb;
    sel       = -1;
    free      = N - q.size();
    exp_issue = '0;
    exp_prf   = '0;
    if (RST) begin
      q.delete();
      return;
    end
    if (issue_ready && !flush_valid) begin
      for (int i = 0; i < q.size() && sel < 0; i++) begin
        if ((q[i].a_rdy || q[i].a_un || hit(q[i].a_pr)) &&
            (q[i].b_rdy || q[i].is_imm || hit(q[i].b_pr))) sel = i;
      end
    end
    if (sel >= 0) begin
      o  = q[sel];
      af = !o.a_rdy && !o.a_un && hit(o.a_pr);
      bf = !o.b_rdy && !o.is_imm && hit(o.b_pr);
      ra = !o.a_un && !af;
      rb = !o.is_imm && !bf;
      exp_issue = {1'b1, o.op, o.is_imm, o.imm, o.a_un,
                   af, af ? 2'(int'(o.a_pr) % NB) : 2'd0,
                   bf, bf ? 2'(int'(o.b_pr) % NB) : 2'd0, o.dest};
      exp_prf   = {ra, ra ? o.a_pr : 6'd0, rb, rb ? o.b_pr : 6'd0};
      q.delete(sel);
    end
    foreach (q[i]) begin
      q[i].a_rdy = q[i].a_rdy || hit(q[i].a_pr);
      q[i].b_rdy = q[i].b_rdy || hit(q[i].b_pr);
    end
    if (flush_valid) q.delete();
    else begin
      for (int w = 0; w < DW; w++) begin
        if (dispatch_valid_by_way[w] && free > w) begin
          o.op     = dispatch_op_by_way[w];
          o.imm    = dispatch_imm_by_way[w];
          o.a_pr   = dispatch_A_PR_by_way[w];
          o.a_un   = dispatch_A_unneeded_by_way[w];
          o.a_rdy  = dispatch_A_ready_by_way[w] || hit(dispatch_A_PR_by_way[w]);
          o.b_pr   = dispatch_B_PR_by_way[w];
          o.is_imm = dispatch_is_imm_by_way[w];
          o.b_rdy  = dispatch_B_ready_by_way[w] || hit(dispatch_B_PR_by_way[w]);
          o.dest   = dispatch_dest_PR_by_way[w];
          q.push_back(o);
        end
      end
    end
  endtask

  task automatic compare();
    logic [DW-1:0] er;
    for (int w = 0; w < DW; w++) er[w] = (N - q.size()) > w;
    check("dispatch_ready", dispatch_ready_by_way, er);
    check("issue_valid", issue_valid, exp_issue[50]);
    check("issue_fields", {issue_valid, issue_op, issue_is_imm, issue_imm, issue_A_unneeded,
                           issue_A_forward, issue_A_bank, issue_B_forward, issue_B_bank,
                           issue_dest_PR}, exp_issue);
    check("prf_req", {PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR}, exp_prf);
  endtask

  // Inputs are driven just after a falling edge; the DUT samples them on the next rising edge.
  task automatic step();
    model_update();
    @(posedge CLK);
    @(negedge CLK);
    compare();
  endtask

  task automatic idle();
    RST = 1'b0; flush_valid = 1'b0; issue_ready = 1'b0;
    dispatch_valid_by_way = '0; dispatch_op_by_way = '0; dispatch_imm_by_way = '0;
    dispatch_A_PR_by_way = '0; dispatch_A_unneeded_by_way = '0; dispatch_A_ready_by_way = '0;
    dispatch_B_PR_by_way = '0; dispatch_is_imm_by_way = '0; dispatch_B_ready_by_way = '0;
    dispatch_dest_PR_by_way = '0; WB_valid_by_bank = '0; WB_upper_PR_by_bank = '0;
  endtask

  task automatic put(input int w, input logic [5:0] dest, input logic [5:0] a, input bit ar,
                     input logic [5:0] b, input bit br, input bit imm_sel);
    dispatch_valid_by_way[w]      = 1'b1;
    dispatch_op_by_way[w]         = 4'h1;
    dispatch_imm_by_way[w]        = {26'h0, dest};
    dispatch_A_PR_by_way[w]       = a;
    dispatch_A_unneeded_by_way[w] = 1'b0;
    dispatch_A_ready_by_way[w]    = ar;
    dispatch_B_PR_by_way[w]       = b;
    dispatch_is_imm_by_way[w]     = imm_sel;
    dispatch_B_ready_by_way[w]    = br;
    dispatch_dest_PR_by_way[w]    = dest;
  endtask

  initial begin
    // Reset, then idle.
    idle(); RST = 1'b1;
    step(); step();
    check("rst_dispatch_ready", dispatch_ready_by_way, 4'b1111);
    check("rst_issue_valid", issue_valid, 1'b0);
    idle(); step();
    check("idle_issue_valid", issue_valid, 1'b0);

    // Single ready op: dispatched in N, selected in N+1, visible in N+2.
    idle(); put(0, 6'd1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0); step();
    idle(); issue_ready = 1'b1; step();
    check("t2_issue_valid", issue_valid, 1'b1);
    check("t2_dest", issue_dest_PR, 6'd1);
    check("t2_req_a_pr", PRF_req_A_PR, 6'd2);
    check("t2_req_b_pr", PRF_req_B_PR, 6'd3);
    check("t2_forwards", {issue_A_forward, issue_B_forward}, 2'b00);

    // Operand woken by bank 2 (upper 1 = PR 6) in the selecting cycle is forwarded.
    idle(); issue_ready = 1'b1; put(0, 6'd5, 6'd6, 1'b0, 6'd0, 1'b0, 1'b1); step();
    idle(); issue_ready = 1'b1; step();
    check("t3_wait", issue_valid, 1'b0);
    idle(); issue_ready = 1'b1; WB_valid_by_bank = 4'b0100; WB_upper_PR_by_bank[2] = 4'd1; step();
    check("t3_issue_valid", issue_valid, 1'b1);
    check("t3_a_forward", issue_A_forward, 1'b1);
    check("t3_a_bank", issue_A_bank, 2'd2);
    check("t3_req_a_valid", PRF_req_A_valid, 1'b0);

    // Fill with non-ready ops, wake only the fourth; full queue refuses dispatch.
    idle();
    for (int k = 0; k < 4; k++) put(k, 6'(32 + k), 6'(16 + k), 1'b0, 6'd0, 1'b0, 1'b1);
    step();
    idle();
    for (int k = 0; k < 4; k++) put(k, 6'(36 + k), 6'(20 + k), 1'b0, 6'd0, 1'b0, 1'b1);
    step();
    check("t4_full_ready", dispatch_ready_by_way, 4'b0000);
    idle();
    for (int k = 0; k < 4; k++) put(k, 6'(50 + k), 6'd1, 1'b1, 6'd1, 1'b1, 1'b0);
    issue_ready = 1'b1; WB_valid_by_bank = 4'b1000; WB_upper_PR_by_bank[3] = 4'd4;
    step();
    check("t4_issue_dest", issue_dest_PR, 6'd35);
    check("t4_a_forward", issue_A_forward, 1'b1);
    check("t4_ready_after", dispatch_ready_by_way, 4'b0001);
    idle(); step();

    // Flush with dispatch in the same cycle drops everything.
    idle(); flush_valid = 1'b1; step();
    idle();
    for (int k = 0; k < 4; k++) put(k, 6'(40 + k), 6'(8 + k), 1'b0, 6'd0, 1'b0, 1'b1);
    step();
    idle(); put(0, 6'd44, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0); put(1, 6'd45, 6'd1, 1'b1, 6'd1, 1'b1, 1'b0);
    flush_valid = 1'b1; issue_ready = 1'b1; step();
    check("t6_issue_valid", issue_valid, 1'b0);
    check("t6_ready", dispatch_ready_by_way, 4'b1111);
    idle(); issue_ready = 1'b1; step();
    check("t6_dropped", issue_valid, 1'b0);

    // Backpressure: nothing issues until issue_ready rises, then oldest first.
    idle(); put(0, 6'd10, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0); put(1, 6'd11, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);
    step();
    for (int c = 0; c < 3; c++) begin
      idle(); step();
      check("t5_hold", issue_valid, 1'b0);
    end
    idle(); issue_ready = 1'b1; step();
    check("t5_first", issue_dest_PR, 6'd10);
    idle(); issue_ready = 1'b1; step();
    check("t5_second", issue_dest_PR, 6'd11);
    check("t5_second_valid", issue_valid, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST         = ($urandom_range(0, 199) == 0);
      flush_valid = ($urandom_range(0, 39) == 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < DW; w++) begin
        dispatch_valid_by_way[w]      = ($urandom_range(0, 2) == 0);
        dispatch_op_by_way[w]         = 4'($urandom);
        dispatch_imm_by_way[w]        = $urandom;
        dispatch_A_PR_by_way[w]       = 6'($urandom_range(0, 15));
        dispatch_A_unneeded_by_way[w] = ($urandom_range(0, 5) == 0);
        dispatch_A_ready_by_way[w]    = ($urandom_range(0, 3) == 0);
        dispatch_B_PR_by_way[w]       = 6'($urandom_range(0, 15));
        dispatch_is_imm_by_way[w]     = ($urandom_range(0, 3) == 0);
        dispatch_B_ready_by_way[w]    = ($urandom_range(0, 3) == 0);
        dispatch_dest_PR_by_way[w]    = 6'($urandom);
      end
      for (int b = 0; b < NB; b++) begin
        WB_valid_by_bank[b]    = ($urandom_range(0, 3) == 0);
        WB_upper_PR_by_bank[b] = 4'($urandom_range(0, 3));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
